// File: rtl/vj_feature_walker.sv
// Viola-Jones cascade walker: fetches one feature per 16 cycles, reads its three
// rectangle sums from the integral image and accumulates stage votes until reject or last feature.
module vj_feature_walker #(
    parameter int NUM_FEATURE = 2913
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic signed [31:0] var_norm,
    output logic [11:0]        feat_addr,
    input  logic [4:0]         r1_x1, r1_y1, r1_x2, r1_y2,
    input  logic [4:0]         r2_x1, r2_y1, r2_x2, r2_y2,
    input  logic [4:0]         r3_x1, r3_y1, r3_x2, r3_y2,
    input  logic signed [31:0] r1_w, r2_w, r3_w,
    input  logic signed [31:0] feat_thresh, feat_above, feat_below, stage_thresh,
    input  logic               is_stage_end,
    output logic [4:0]         ii_x,
    output logic [4:0]         ii_y,
    input  logic signed [31:0] ii_data,
    output logic               busy,
    output logic               done,
    output logic               face
);
    localparam int DATA_W = 32;
    localparam logic [11:0] LAST_ADDR = 12'(NUM_FEATURE - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_READ, S_EVAL, S_DONE} state_t;

    function automatic logic signed [DATA_W-1:0] mul_wrap(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
        return a * b;
    endfunction

    state_t state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [3:0]  k_q, k_d;
    logic [4:0]  iix_q, iix_d, iiy_q, iiy_d;
    logic        face_q, face_d, send_q, send_d;
    logic signed [DATA_W-1:0] acc_q, acc_d, vnorm_q, vnorm_d;
    logic signed [DATA_W-1:0] fth_q, fth_d, above_q, above_d, below_q, below_d, sth_q, sth_d;
    logic [4:0]  x1_q [3], y1_q [3], x2_q [3], y2_q [3];
    logic [4:0]  x1_d [3], y1_d [3], x2_d [3], y2_d [3];
    logic signed [DATA_W-1:0] w_q [3], w_d [3], rs_q [3], rs_d [3];
    logic signed [DATA_W-1:0] fv, th, acc_upd;
    logic        reject, last;
    logic [3:0]  nxt, prv;

    always_comb begin
        fv      = mul_wrap(w_q[0], rs_q[0]) + mul_wrap(w_q[1], rs_q[1]) + mul_wrap(w_q[2], rs_q[2]);
        th      = mul_wrap(fth_q, vnorm_q);
        acc_upd = acc_q + ((fv < th) ? below_q : above_q);
        reject  = send_q && (acc_upd < sth_q);
        last    = (addr_q == LAST_ADDR);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_READ;
            S_READ:  if (k_q == 4'd12) state_d = S_EVAL;
            S_EVAL:  state_d = (reject || last) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;  k_d     = k_q;     iix_d = iix_q;   iiy_d = iiy_q;
        face_d  = face_q;  send_d  = send_q;  acc_d = acc_q;   vnorm_d = vnorm_q;
        fth_d   = fth_q;   above_d = above_q; below_d = below_q; sth_d = sth_q;
        for (int i = 0; i < 3; i++) begin
            x1_d[i] = x1_q[i]; y1_d[i] = y1_q[i]; x2_d[i] = x2_q[i]; y2_d[i] = y2_q[i];
            w_d[i]  = w_q[i];  rs_d[i] = rs_q[i];
        end
        nxt = k_q + 4'd1;
        prv = k_q - 4'd1;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = '0;
                acc_d   = '0;
                face_d  = 1'b0;
                vnorm_d = var_norm;
            end
            S_LATCH: begin
                x1_d[0] = r1_x1; y1_d[0] = r1_y1; x2_d[0] = r1_x2; y2_d[0] = r1_y2;
                x1_d[1] = r2_x1; y1_d[1] = r2_y1; x2_d[1] = r2_x2; y2_d[1] = r2_y2;
                x1_d[2] = r3_x1; y1_d[2] = r3_y1; x2_d[2] = r3_x2; y2_d[2] = r3_y2;
                w_d[0] = r1_w; w_d[1] = r2_w; w_d[2] = r3_w;
                fth_d = feat_thresh; above_d = feat_above; below_d = feat_below;
                sth_d = stage_thresh; send_d = is_stage_end;
                for (int i = 0; i < 3; i++) rs_d[i] = '0;
                // First corner comes straight from the ROM so READ cycle 0 already drives it
                iix_d = r1_x1;
                iiy_d = r1_y1;
                k_d   = '0;
            end
            S_READ: begin
                k_d = nxt;
                if (k_q < 4'd11) begin
                    iix_d = nxt[0] ? x2_q[nxt[3:2]] : x1_q[nxt[3:2]];
                    iiy_d = nxt[1] ? y2_q[nxt[3:2]] : y1_q[nxt[3:2]];
                end
                // Corners B and C subtract, A and D add
                if (k_q != 4'd0) begin
                    if (prv[0] ^ prv[1]) rs_d[prv[3:2]] = rs_q[prv[3:2]] - ii_data;
                    else                 rs_d[prv[3:2]] = rs_q[prv[3:2]] + ii_data;
                end
            end
            S_EVAL: begin
                acc_d = (send_q && !reject) ? '0 : acc_upd;
                if (reject)    face_d = 1'b0;
                else if (last) face_d = 1'b1;
                else           addr_d = addr_q + 12'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;  addr_q <= '0;  k_q <= '0;  iix_q <= '0;  iiy_q <= '0;
            face_q  <= 1'b0;    send_q <= 1'b0; acc_q <= '0; vnorm_q <= '0;
            fth_q   <= '0;      above_q <= '0;  below_q <= '0; sth_q <= '0;
            for (int i = 0; i < 3; i++) begin
                x1_q[i] <= '0; y1_q[i] <= '0; x2_q[i] <= '0; y2_q[i] <= '0;
                w_q[i]  <= '0; rs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d; addr_q <= addr_d; k_q <= k_d; iix_q <= iix_d; iiy_q <= iiy_d;
            face_q  <= face_d;  send_q <= send_d; acc_q <= acc_d; vnorm_q <= vnorm_d;
            fth_q   <= fth_d;   above_q <= above_d; below_q <= below_d; sth_q <= sth_d;
            for (int i = 0; i < 3; i++) begin
                x1_q[i] <= x1_d[i]; y1_q[i] <= y1_d[i]; x2_q[i] <= x2_d[i]; y2_q[i] <= y2_d[i];
                w_q[i]  <= w_d[i];  rs_q[i] <= rs_d[i];
            end
        end
    end

    always_comb begin
        feat_addr = addr_q;
        ii_x      = iix_q;
        ii_y      = iiy_q;
        face      = face_q;
        done      = (state_q == S_DONE);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    end
endmodule

// File: tb/tb_vj_feature_walker.sv
// Bench for vj_feature_walker: behavioural ROM / integral-image memories and a
// feature-loop reference model of the cascade decision and its latency.
module tb_vj_feature_walker;
    localparam int NF = 2;

    logic clock, reset_n, start;
    logic signed [31:0] var_norm;
    logic [11:0] feat_addr;
    logic [4:0]  r1_x1, r1_y1, r1_x2, r1_y2, r2_x1, r2_y1, r2_x2, r2_y2;
    logic [4:0]  r3_x1, r3_y1, r3_x2, r3_y2;
    logic signed [31:0] r1_w, r2_w, r3_w, feat_thresh, feat_above, feat_below, stage_thresh;
    logic        is_stage_end;
    logic [4:0]  ii_x, ii_y;
    logic signed [31:0] ii_data;
    logic        busy, done, face;

    vj_feature_walker #(.NUM_FEATURE(NF)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .var_norm(var_norm), .feat_addr(feat_addr),
        .r1_x1(r1_x1), .r1_y1(r1_y1), .r1_x2(r1_x2), .r1_y2(r1_y2),
        .r2_x1(r2_x1), .r2_y1(r2_y1), .r2_x2(r2_x2), .r2_y2(r2_y2),
        .r3_x1(r3_x1), .r3_y1(r3_y1), .r3_x2(r3_x2), .r3_y2(r3_y2),
        .r1_w(r1_w), .r2_w(r2_w), .r3_w(r3_w), .feat_thresh(feat_thresh), .feat_above(feat_above),
        .feat_below(feat_below), .stage_thresh(stage_thresh), .is_stage_end(is_stage_end),
        .ii_x(ii_x), .ii_y(ii_y), .ii_data(ii_data), .busy(busy), .done(done), .face(face)
    );

    logic [4:0] tx1 [NF][3], ty1 [NF][3], tx2 [NF][3], ty2 [NF][3];
    int tw [NF][3];
    int tfth [NF], tab [NF], tbe [NF], tsth [NF];
    bit tse [NF];
    int iim [32][32];
    int n_cmp, n_err;
    int ra;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cascade ROM and integral image, both with one cycle of read latency
    always @(posedge clock) begin
        ra = (feat_addr < 12'(NF)) ? int'(feat_addr) : 0;
        r1_x1 <= tx1[ra][0]; r1_y1 <= ty1[ra][0]; r1_x2 <= tx2[ra][0]; r1_y2 <= ty2[ra][0];
        r2_x1 <= tx1[ra][1]; r2_y1 <= ty1[ra][1]; r2_x2 <= tx2[ra][1]; r2_y2 <= ty2[ra][1];
        r3_x1 <= tx1[ra][2]; r3_y1 <= ty1[ra][2]; r3_x2 <= tx2[ra][2]; r3_y2 <= ty2[ra][2];
        r1_w <= tw[ra][0]; r2_w <= tw[ra][1]; r3_w <= tw[ra][2];
        feat_thresh <= tfth[ra]; feat_above <= tab[ra]; feat_below <= tbe[ra];
        stage_thresh <= tsth[ra]; is_stage_end <= tse[ra];
        ii_data <= iim[ii_x][ii_y];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rect_sum(input logic [4:0] x1, input logic [4:0] y1,
                                    input logic [4:0] x2, input logic [4:0] y2);
        return iim[x2][y2] - iim[x2][y1] - iim[x1][y2] + iim[x1][y1];
    endfunction

    // Walk the cascade feature by feature; returns decision and features evaluated
    task automatic model(input int vn, output bit fc, output int nf);
        int acc, fv, th;
        acc = 0; fc = 1'b1; nf = NF;
        for (int f = 0; f < NF; f++) begin
            fv = 0;
            for (int r = 0; r < 3; r++)
                fv += tw[f][r] * rect_sum(tx1[f][r], ty1[f][r], tx2[f][r], ty2[f][r]);
            th = tfth[f] * vn;
            acc += (fv < th) ? tbe[f] : tab[f];
            if (tse[f]) begin
                if (acc < tsth[f]) begin
                    fc = 1'b0; nf = f + 1;
                    return;
                end
                acc = 0;
            end
        end
    endtask

    task automatic base_cfg();
        for (int x = 0; x < 32; x++) for (int y = 0; y < 32; y++) iim[x][y] = 0;
        for (int f = 0; f < NF; f++) begin
            for (int r = 0; r < 3; r++) begin
                tx1[f][r] = '0; ty1[f][r] = '0; tx2[f][r] = '0; ty2[f][r] = '0; tw[f][r] = 0;
            end
            tfth[f] = 1; tab[f] = 0; tbe[f] = 5; tsth[f] = 5; tse[f] = 1'b1;
        end
        var_norm = 32'sd1;
    endtask

    task automatic run(input string tag, input bit spam, input bit exp_face, input int exp_f);
        int cyc;
        bit seen, addr_ok;
        logic [11:0] prev;
        @(negedge clock);
        start = 1'b1;
        cyc = 0; seen = 1'b0; addr_ok = 1'b1; prev = '0;
        while (!seen && cyc < 16 * NF + 20) begin
            @(negedge clock);
            cyc++;
            if (!spam) start = 1'b0;
            if (cyc == 1) check({tag, "_busy_first"}, 32'(busy), 32'd1);
            if (feat_addr != prev && feat_addr != prev + 12'd1) addr_ok = 1'b0;
            prev = feat_addr;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(16 * exp_f + 1));
        check({tag, "_face"}, 32'(face), 32'(exp_face));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_last_addr"}, 32'(feat_addr), 32'(exp_f - 1));
        check({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
        check({tag, "_ii_x_hold"}, 32'(ii_x), 32'(tx2[exp_f-1][2]));
        check({tag, "_ii_y_hold"}, 32'(ii_y), 32'(ty2[exp_f-1][2]));
        @(negedge clock);
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        @(negedge clock);
        check({tag, "_no_restart"}, 32'(busy), 32'd0);
        check({tag, "_face_held"}, 32'(face), 32'(exp_face));
    endtask

    task automatic run_model(input string tag, input bit spam);
        bit fc;
        int nf;
        model(var_norm, fc, nf);
        run(tag, spam, fc, nf);
    endtask

    initial begin
        bit fc;
        int nf, fv_exp;
        n_cmp = 0; n_err = 0;
        reset_n = 1'b0; start = 1'b0;
        base_cfg();
        repeat (2) @(negedge clock);
        check("rst_addr", 32'(feat_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_face", 32'(face), 32'd0);
        check("rst_iix", 32'(ii_x), 32'd0);
        reset_n = 1'b1;

        // Two passing stages
        base_cfg();
        run("pass2", 1'b0, 1'b1, 2);

        // Reject at the first stage
        base_cfg();
        tbe[0] = 4;
        run("rej0", 1'b0, 1'b0, 1);

        // Rectangle arithmetic on ii(x,y)=x*y, both sides of the threshold
        base_cfg();
        for (int x = 0; x < 32; x++) for (int y = 0; y < 32; y++) iim[x][y] = x * y;
        tx1[0][0] = 0; ty1[0][0] = 0; tx2[0][0] = 2; ty2[0][0] = 2; tw[0][0] = -1;
        tx1[0][1] = 1; ty1[0][1] = 1; tx2[0][1] = 3; ty2[0][1] = 3; tw[0][1] = 2;
        tx1[0][2] = 5; ty1[0][2] = 6; tx2[0][2] = 7; ty2[0][2] = 8; tw[0][2] = 0;
        tab[0] = -100; tsth[0] = 0;
        fv_exp = -rect_sum(0, 0, 2, 2) + 2 * rect_sum(1, 1, 3, 3);
        tfth[0] = fv_exp + 1;
        run("arith_below", 1'b0, 1'b1, 2);
        tfth[0] = fv_exp;
        run("arith_above", 1'b0, 1'b0, 1);

        // Negative stage compare
        base_cfg();
        tbe[0] = -3; tsth[0] = -2;
        run("neg_reject", 1'b0, 1'b0, 1);
        tbe[0] = -2;
        run("neg_pass", 1'b0, 1'b1, 2);

        // Last feature without a stage end still accepts
        base_cfg();
        tse[0] = 1'b0; tse[1] = 1'b0;
        run("no_stage_end", 1'b0, 1'b1, 2);

        // Start held high through busy and DONE
        base_cfg();
        run("start_spam", 1'b1, 1'b1, 2);

        // Asynchronous reset in the middle of READ
        base_cfg();
        tx1[0][0] = 3; ty1[0][0] = 4; tx2[0][0] = 7; ty2[0][0] = 9;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_iix_c", 32'(ii_x), 32'd3);
        check("mid_iiy_c", 32'(ii_y), 32'd9);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_iix", 32'(ii_x), 32'd0);
        check("mid_rst_iiy", 32'(ii_y), 32'd0);
        check("mid_rst_addr", 32'(feat_addr), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_face", 32'(face), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        base_cfg();
        run("after_reset", 1'b0, 1'b1, 2);

        // Randomized cascades against the reference model
        for (int it = 0; it < 24; it++) begin
            for (int x = 0; x < 32; x++)
                for (int y = 0; y < 32; y++) iim[x][y] = int'($urandom_range(0, 40)) - 20;
            for (int f = 0; f < NF; f++) begin
                for (int r = 0; r < 3; r++) begin
                    tx1[f][r] = 5'($urandom_range(0, 31)); ty1[f][r] = 5'($urandom_range(0, 31));
                    tx2[f][r] = 5'($urandom_range(0, 31)); ty2[f][r] = 5'($urandom_range(0, 31));
                    tw[f][r] = int'($urandom_range(0, 6)) - 3;
                end
                tfth[f] = int'($urandom_range(0, 8)) - 4;
                tab[f]  = int'($urandom_range(0, 40)) - 20;
                tbe[f]  = int'($urandom_range(0, 40)) - 20;
                tsth[f] = int'($urandom_range(0, 20)) - 10;
                tse[f]  = 1'($urandom_range(0, 1));
            end
            var_norm = int'($urandom_range(0, 6)) - 3;
            run_model($sformatf("rand%0d", it), (it % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
